// File: rtl/conf_uart_tx.sv
// conf_uart_tx: sends a table of CONF_PAR_MAX configuration bytes as one
// gap-free burst of 8N1 UART frames, LSB first, with the line idle high.
// A start request in IDLE captures the whole parameter table. Later changes
// to params therefore do not affect a burst that is already running.
//
// Ports
//   clk      single clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   start    request to transmit the full table (honoured only in IDLE)
//   params   flattened table, byte i at [8*i+7:8*i]
//   uart_tx  registered serial line
//   busy     high while a burst is in progress
//   done     one-cycle pulse in the first IDLE cycle after the last stop bit
module conf_uart_tx #(
  parameter int CONF_PAR_MAX = 8,
  parameter int BIT_CNT_MAX  = 5208
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CONF_PAR_MAX*8-1:0] params,
  output logic                      uart_tx,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
  localparam int IDX_W = (CONF_PAR_MAX > 1) ? $clog2(CONF_PAR_MAX) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CONF_PAR_MAX - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               bit_cnt, bit_cnt_n;
  logic [2:0]                     data_cnt, data_cnt_n;
  logic [IDX_W-1:0]               index, index_n;
  logic [CONF_PAR_MAX-1:0][7:0]   tbl;
  logic                           load, tx_n, done_n;
  logic                           bit_end;

  assign bit_end = (bit_cnt == BIT_LAST);

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    data_cnt_n = data_cnt;
    index_n    = index;
    load       = 1'b0;
    done_n     = 1'b0;
    tx_n       = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          index_n    = '0;
          bit_cnt_n  = '0;
          data_cnt_n = '0;
          state_n    = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = DATA_BITS;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (data_cnt == 3'd7) begin
            data_cnt_n = '0;
            state_n    = STOP_BIT;
          end else begin
            data_cnt_n = data_cnt + 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (index == IDX_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            // The next start bit follows at once, with no idle gap.
            index_n = index + 1'b1;
            state_n = START_BIT;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // The line level is decoded from the next state and registered. This
    // keeps the pin glitch-free and avoids an extra cycle of latency. The
    // table is never read on the accept edge, because that edge always
    // selects the start bit.
    case (state_n)
      START_BIT: tx_n = 1'b0;
      DATA_BITS: tx_n = tbl[index_n][data_cnt_n];
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_cnt <= '0;
      index    <= '0;
      tbl      <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      data_cnt <= data_cnt_n;
      index    <= index_n;
      if (load) tbl <= params;
      uart_tx  <= tx_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_conf_uart_tx.sv
// tb_conf_uart_tx: self-checking bench for conf_uart_tx with 2 bytes and
// 4 clocks per bit. The expected line level is computed from the frame
// layout (start, 8 data LSB first, stop) by cycle arithmetic. Inputs are
// driven and outputs sampled on the falling edge.
module tb_conf_uart_tx;

  localparam int N   = 2;
  localparam int B   = 4;
  localparam int TOT = N * 10 * B;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N*8-1:0] params = '0;
  logic          uart_tx, busy, done;

  int n_chk = 0;
  int n_err = 0;

  conf_uart_tx #(.CONF_PAR_MAX(N), .BIT_CNT_MAX(B)) dut (
    .clk(clk), .rst(rst), .start(start), .params(params),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line level k cycles after the first start-bit cycle.
  function automatic logic line_at(input logic [N*8-1:0] p, input int k);
    int b, byt, pos;
    b   = k / B;
    byt = b / 10;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return p[byt*8 + pos - 1];
  endfunction

  // Entered at the falling edge of the first start-bit cycle; returns at
  // the falling edge of the done cycle.
  task automatic check_frame(input logic [N*8-1:0] p, input int poke,
                             input bit chg, input bit hold);
    for (int k = 0; k < TOT; k++) begin
      chk("line", uart_tx, line_at(p, k));
      chk("busy", busy, 1'b1);
      chk("done_lo", done, 1'b0);
      if (!hold) start = (k == poke);
      if (chg && k == 0) params = '1;
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("line_done", uart_tx, 1'b1);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_line", uart_tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end
  endtask

  task automatic burst(input logic [N*8-1:0] p, input int poke, input bit chg);
    params = p;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_frame(p, poke, chg, 1'b0);
    idle_check(3);
  endtask

  initial begin
    logic [N*8-1:0] rp;
    // Reset state, with start requested during reset.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_line", uart_tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    start = 1'b0;
    idle_check(3);

    // Basic burst, a restart request while busy, and a params change mid-burst.
    burst(16'hA53C, -1, 1'b0);
    burst(16'hA53C, 10, 1'b0);
    burst(16'hA53C, -1, 1'b1);
    burst(16'h00FF, -1, 1'b0);

    // Back-to-back: start held high, the next burst begins right after done.
    params = 16'h5AC3;
    start  = 1'b1;
    @(negedge clk);
    check_frame(16'h5AC3, -1, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_frame(16'h5AC3, -1, 1'b0, 1'b0);
    idle_check(3);

    // Reset in the middle of a data bit of byte 0, with start also requested.
    params = 16'h1234;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * B + 1) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_line", uart_tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    idle_check(2 * 10 * B);

    // Randomized tables and restart points.
    for (int t = 0; t < 6; t++) begin
      rp = N*8'($urandom);
      burst(rp, int'($urandom_range(0, TOT - 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
